mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage RV32I pipeline. Data accesses win ties; a streak limit prevents fetch starvation. Per-requester stall outputs feed the hazard unit. Fetch flushes from a taken branch drop in-flight fetch responses, and a watchdog converts a hung memory into a defined response plus a sticky error.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and constants for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

  // Arbiter FSM: idle, or owning the memory on behalf of fetch or data
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_t;

  // addi x0, x0, 0 -- handed to the fetch stage when its access times out
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - busy-cycle counter that flags a memory transaction stuck for TIMEOUT cycles
module mem_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Counter value n means this is the (n+1)th busy cycle without a response
  assign expire = enable & (cnt == CW'(TIMEOUT - 1));

  // Count stalled busy cycles; restart on any completion, abort or idle cycle
  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between the fetch and data stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DGRANTS = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush_if,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int SW = $clog2(MAX_DGRANTS + 1);

  arb_state_t    state;
  arb_state_t    next_state;
  logic          busy;
  logic          expire;
  logic          xact_done;
  logic          if_done;
  logic          dm_done;
  logic          arb_point;
  logic          if_elig;
  logic          dm_elig;
  logic          grant_if;
  logic          grant_dm;
  logic          drop;
  logic [SW-1:0] dm_streak;

  assign busy      = (state != IDLE);
  assign xact_done = busy & (mem_ready | expire);
  assign if_done   = xact_done & (state == IF_BUSY);
  assign dm_done   = xact_done & (state == DM_BUSY);
  assign arb_point = ~busy | xact_done;

  // A request still showing its valid strobe is the one just served, not a new one
  assign if_elig = if_req & ~if_valid & ~flush_if & ~if_done;
  assign dm_elig = dm_req & ~dm_valid & ~dm_done;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (~busy | mem_ready),
    .enable(busy & ~mem_ready),
    .expire(expire)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Arbitration: data wins ties unless the waiting fetch has hit its streak limit
  always_comb begin
    next_state = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    if (arb_point) begin
      if (if_elig && (!dm_elig || dm_streak == SW'(MAX_DGRANTS))) begin
        grant_if   = 1'b1;
        next_state = IF_BUSY;
      end else if (dm_elig) begin
        grant_dm   = 1'b1;
        next_state = DM_BUSY;
      end else begin
        next_state = IDLE;
      end
    end
  end

  // Memory-side request registers, held stable for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
    end else if (grant_dm) begin
      mem_req   <= 1'b1;
      mem_we    <= dm_we;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end else if (arb_point) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Fetch response: one-cycle strobe unless the fetch was flushed while in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      if (if_done && !(drop || flush_if)) begin
        if_valid <= 1'b1;
        if_rdata <= expire ? DATA_W'(NOP_INSTR) : mem_rdata;
      end
    end
  end

  // Data response: stores and aborted accesses return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_valid <= 1'b0;
      dm_rdata <= '0;
    end else begin
      dm_valid <= 1'b0;
      if (dm_done) begin
        dm_valid <= 1'b1;
        dm_rdata <= (expire || mem_we) ? '0 : mem_rdata;
      end
    end
  end

  // Drop flag for a redirected fetch; sticky timeout error
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (if_done) begin
        drop <= 1'b0;
      end else if (state == IF_BUSY && flush_if) begin
        drop <= 1'b1;
      end
      if (expire) begin
        err <= 1'b1;
      end
    end
  end

  // Consecutive data grants taken while a fetch is requesting
  always_ff @(posedge clk) begin
    if (rst || !if_req || grant_if) begin
      dm_streak <= '0;
    end else if (grant_dm && dm_streak != SW'(MAX_DGRANTS)) begin
      dm_streak <= dm_streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int MAXD = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush_if, if_valid, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, stall_mem;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state for the randomized phase
  bit          t_act, t_own_dm, t_we, t_fl;
  logic [31:0] t_addr, t_wdata;
  int          t_lat;
  bit          e_ifv, e_dmv;
  logic [31:0] e_ifd, e_dmd;
  bit          p_arb;
  int          p_win;
  logic [31:0] g_addr, g_wdata;
  bit          g_we;
  int          streak;
  bit          done_c, ife, dme;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DGRANTS(MAXD), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
    .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; flush_if = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] faddr();
    return 32'($urandom_range(0, 16383)) << 2;
  endfunction

  initial begin
    // Reset values
    do_reset();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_if_valid", 32'(if_valid), 0);
    check("rst_dm_valid", 32'(dm_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_addr", mem_addr, 0);

    // Single fetch with 1-cycle memory
    if_req = 1; if_addr = 32'h100;
    #1 check("f1_stall_c0", 32'(stall_if), 1);
    tick();
    check("f1_mem_req", 32'(mem_req), 1);
    check("f1_mem_addr", mem_addr, 32'h100);
    check("f1_stall_c1", 32'(stall_if), 1);
    mem_ready = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 0;
    check("f1_if_valid", 32'(if_valid), 1);
    check("f1_if_rdata", if_rdata, 32'hCAFE_0001);
    check("f1_stall_c2", 32'(stall_if), 0);
    check("f1_mem_idle", 32'(mem_req), 0);
    if_req = 0;
    tick();
    check("f1_valid_once", 32'(if_valid), 0);
    check("f1_no_regrant", 32'(mem_req), 0);

    // Simultaneous requests: store first, fetch back-to-back on its completion
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("tie_mem_addr", mem_addr, 32'h200);
    check("tie_mem_we", 32'(mem_we), 1);
    check("tie_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ready = 1; mem_rdata = 32'h1111_1111;
    tick();
    check("tie_no_bubble", 32'(mem_req), 1);
    check("tie_fetch_addr", mem_addr, 32'h300);
    check("tie_fetch_we", 32'(mem_we), 0);
    check("tie_dm_valid", 32'(dm_valid), 1);
    check("tie_store_rdata", dm_rdata, 0);
    dm_req = 0; dm_we = 0;
    mem_rdata = 32'h00A0_0093;
    tick();
    mem_ready = 0;
    check("tie_if_valid", 32'(if_valid), 1);
    check("tie_if_rdata", if_rdata, 32'h00A0_0093);
    if_req = 0;
    tick();

    // Streak limit: fetch ineligible (flush) except at idle tie points
    if_req = 1; if_addr = 32'h400;
    for (int r = 0; r < MAXD; r++) begin
      dm_req = 1; dm_addr = 32'h800 + 32'(r) * 4; flush_if = 0;
      tick();
      check("streak_data_grant", mem_addr, 32'h800 + 32'(r) * 4);
      flush_if = 1; mem_ready = 1; mem_rdata = 32'(r);
      tick();
      mem_ready = 0;
      check("streak_dm_valid", 32'(dm_valid), 1);
      dm_req = 0;
      tick();
    end
    dm_req = 1; dm_addr = 32'h810; flush_if = 0;
    tick();
    check("streak_fetch_wins", mem_addr, 32'h400);
    check("streak_fetch_we", 32'(mem_we), 0);
    mem_ready = 1; mem_rdata = 32'h0040_0413;
    tick();
    check("streak_if_valid", 32'(if_valid), 1);
    check("streak_if_rdata", if_rdata, 32'h0040_0413);
    check("streak_data_resume", mem_addr, 32'h810);
    check("streak_resume_req", 32'(mem_req), 1);
    if_req = 0; mem_rdata = 32'h55;
    tick();
    mem_ready = 0;
    check("streak_dm_rdata", dm_rdata, 32'h55);
    dm_req = 0;
    tick();

    // Flush during IF_BUSY drops the response; redirected fetch proceeds
    if_req = 1; if_addr = 32'h500;
    tick();
    check("drop_mem_addr", mem_addr, 32'h500);
    flush_if = 1; if_addr = 32'h600;
    tick();
    flush_if = 0;
    check("drop_hold_addr", mem_addr, 32'h500);
    mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ready = 0;
    check("drop_no_valid", 32'(if_valid), 0);
    tick();
    check("drop_new_grant", mem_addr, 32'h600);
    check("drop_new_req", 32'(mem_req), 1);
    mem_ready = 1; mem_rdata = 32'h0060_0013;
    tick();
    mem_ready = 0;
    check("drop_new_valid", 32'(if_valid), 1);
    check("drop_new_rdata", if_rdata, 32'h0060_0013);
    if_req = 0;
    tick();

    // Watchdog: memory never answers
    if_req = 1; if_addr = 32'h700;
    tick();
    check("tmo_req_c1", 32'(mem_req), 1);
    repeat (TMO - 1) tick();
    check("tmo_err_c64", 32'(err), 0);
    check("tmo_busy_c64", 32'(mem_req), 1);
    check("tmo_novalid_c64", 32'(if_valid), 0);
    tick();
    check("tmo_if_valid", 32'(if_valid), 1);
    check("tmo_nop", if_rdata, 32'h0000_0013);
    check("tmo_err", 32'(err), 1);
    check("tmo_mem_idle", 32'(mem_req), 0);
    if_req = 0;
    repeat (3) tick();
    check("tmo_err_sticky", 32'(err), 1);

    // Reset mid data transaction
    dm_req = 1; dm_we = 0; dm_addr = 32'h900;
    tick();
    check("rstx_busy", 32'(mem_req), 1);
    rst = 1; dm_req = 0;
    tick();
    rst = 0;
    check("rstx_mem_req", 32'(mem_req), 0);
    check("rstx_err", 32'(err), 0);
    for (int i = 0; i < 4; i++) begin
      check("rstx_no_dm_valid", 32'(dm_valid), 0);
      tick();
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    t_act = 0; e_ifv = 0; e_dmv = 0; p_arb = 1; p_win = 0; streak = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      check("rnd_if_valid", 32'(if_valid), 32'(e_ifv));
      if (e_ifv) check("rnd_if_rdata", if_rdata, e_ifd);
      check("rnd_dm_valid", 32'(dm_valid), 32'(e_dmv));
      if (e_dmv) check("rnd_dm_rdata", dm_rdata, e_dmd);
      if (p_arb) begin
        check("rnd_grant", 32'(mem_req), 32'(p_win != 0));
        if (p_win != 0) begin
          check("rnd_grant_addr", mem_addr, g_addr);
          check("rnd_grant_we", 32'(mem_we), 32'(g_we));
          if (p_win == 2) check("rnd_grant_wdata", mem_wdata, g_wdata);
          t_act = 1; t_own_dm = (p_win == 2); t_addr = g_addr; t_we = g_we;
          t_wdata = g_wdata; t_fl = 0; t_lat = $urandom_range(0, 4);
        end
      end else begin
        check("rnd_busy", 32'(mem_req), 1);
        check("rnd_hold_addr", mem_addr, t_addr);
        check("rnd_hold_we", 32'(mem_we), 32'(t_we));
      end

      if (e_ifv) if_req = 0;
      else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = faddr();
      end
      flush_if = 0;
      if (if_req && !e_ifv && $urandom_range(0, 15) == 0) begin
        flush_if = 1; if_addr = faddr();
        if (t_act && !t_own_dm) t_fl = 1;
      end
      if (e_dmv) dm_req = 0;
      else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h8000_0000 | (32'($urandom_range(0, 16383)) << 2);
        dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      if (t_act) begin
        if (t_lat == 0) mem_ready = 1;
        else begin
          mem_ready = 0; t_lat--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      check("rnd_stall_if", 32'(stall_if), 32'(if_req && !e_ifv));
      check("rnd_stall_mem", 32'(stall_mem), 32'(dm_req && !e_dmv));

      done_c = t_act && mem_ready;
      e_ifv = done_c && !t_own_dm && !t_fl;
      e_ifd = mem_rdata;
      e_dmv = done_c && t_own_dm;
      e_dmd = t_we ? 32'h0 : mem_rdata;
      ife = if_req && !flush_if && !(done_c && !t_own_dm);
      dme = dm_req && !(done_c && t_own_dm);
      p_arb = !t_act || done_c;
      p_win = 0;
      if (p_arb) begin
        if (ife && (!dme || streak == MAXD)) p_win = 1;
        else if (dme) p_win = 2;
      end
      if (p_win == 1) begin
        g_addr = if_addr; g_we = 0; g_wdata = 0;
      end else if (p_win == 2) begin
        g_addr = dm_addr; g_we = dm_we; g_wdata = dm_wdata;
      end
      if (!if_req || p_win == 1) streak = 0;
      else if (p_win == 2 && streak < MAXD) streak++;
      if (done_c) t_act = 0;
    end
    check("rnd_err_clear", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
